microseq: RTL and testbench

- Parametrised microprogram sequencer for the multicycle CPU datapath.
- Successor to the fixed 4-bit-state controller: it generalises the control-store address width, control-word width and condition count.
- New capabilities: conditional branch with polarity select, opcode map dispatch, a wait stall, a microsubroutine stack (call/return) and halt.
- The control store stays an external asynchronous ROM, in the controllerROM style.
- The sequencer drives the ROM address and the datapath control bus.

---
 rtl/microseq_pkg.sv | 42 ++++
 rtl/microseq_stack.sv | 61 ++++++
 rtl/microseq.sv | 133 +++++++++++++
 tb/tb_microseq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// microseq_pkg: shared definitions for the microprogram sequencer.
//   - mode_e: the eight sequencing modes carried in the microword mode field.
//   - field position helpers: the microword is packed MSB to LSB as
//     ctrl | mode | cinv | csel | naddr. Each helper returns the LSB index of
//     one field for a given set of widths.
//   - f_uword_w: total microword width for a given set of widths.
package microseq_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        M_NEXT  = 3'd0,
        M_JUMP  = 3'd1,
        M_CJUMP = 3'd2,
        M_MAP   = 3'd3,
        M_CALL  = 3'd4,
        M_RET   = 3'd5,
        M_WAIT  = 3'd6,
        M_HALT  = 3'd7
    } mode_e;

    function automatic int f_csel_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int f_cinv_lsb(input int addr_w, input int csel_w);
        return addr_w + csel_w;
    endfunction

    function automatic int f_mode_lsb(input int addr_w, input int csel_w);
        return addr_w + csel_w + 1;
    endfunction

    function automatic int f_ctrl_lsb(input int addr_w, input int csel_w);
        return addr_w + csel_w + 1 + MODE_W;
    endfunction

    function automatic int f_uword_w(input int ctrl_w, input int csel_w, input int addr_w);
        return ctrl_w + MODE_W + 1 + csel_w + addr_w;
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// useq_stack: parametrised LIFO holding microsubroutine return addresses.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset (clears sp only)
//   push, din    : write din on top of the stack; ignored when full
//   pop          : discard the top entry; ignored when empty
//   dout         : current top entry (don't-care when empty)
//   full, empty  : occupancy flags
// Handshake: push and pop are single-cycle strobes; the caller never raises
// both in the same cycle and checks full/empty before relying on the result.
module useq_stack
    import microseq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0] sp_q, sp_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        dout  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // sp points one past the top entry.
            if (sp_q == SP_W'(i + 1)) dout = mem_q[i];
            if (push && !full && (sp_q == SP_W'(i))) mem_d[i] = din;
        end
        if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
        // Entry contents are meaningless until pushed, so they carry no reset.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/microseq.sv
// microseq: parametrised microprogram sequencer for the multicycle datapath.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   uaddr           : current microaddress, drives the external control-store ROM
//   uword           : microword returned combinationally by the ROM for uaddr
//   cond            : branch condition inputs, indexed by the csel field
//   map_addr        : opcode-decoded dispatch target for MAP
//   wait_           : memory ready (low = not ready), stalls WAIT words
//   bus_controller  : ctrl field of the current microword, zero during reset
//   halted          : current word is HALT (and reset is low)
//   stack_err       : sticky return-stack overflow/underflow flag
module microseq
    import microseq_pkg::*;
#(
    parameter  int ADDR_W      = 4,
    parameter  int CTRL_W      = 22,
    parameter  int NCOND       = 4,
    parameter  int CSEL_W      = 2,
    parameter  int STACK_DEPTH = 4,
    parameter  int RESET_ADDR  = 0,
    localparam int UWORD_W     = f_uword_w(CTRL_W, CSEL_W, ADDR_W)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  uaddr,
    input  logic [UWORD_W-1:0] uword,
    input  logic [NCOND-1:0]   cond,
    input  logic [ADDR_W-1:0]  map_addr,
    input  logic               wait_,
    output logic [CTRL_W-1:0]  bus_controller,
    output logic               halted,
    output logic               stack_err
);

    localparam int CSEL_LSB = f_csel_lsb(ADDR_W);
    localparam int CINV_LSB = f_cinv_lsb(ADDR_W, CSEL_W);
    localparam int MODE_LSB = f_mode_lsb(ADDR_W, CSEL_W);
    localparam int CTRL_LSB = f_ctrl_lsb(ADDR_W, CSEL_W);
    localparam logic [ADDR_W-1:0] RESET_UADDR = ADDR_W'(RESET_ADDR);

    logic [ADDR_W-1:0] upc_q, upc_d;
    logic              stack_err_q, stack_err_d;

    // Microword fields.
    logic [CTRL_W-1:0] f_ctrl;
    mode_e             f_mode;
    logic              f_cinv;
    logic [CSEL_W-1:0] f_csel;
    logic [ADDR_W-1:0] f_naddr;

    logic              cond_bit;
    logic [ADDR_W-1:0] upc_inc;
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_dout;

    assign f_ctrl  = uword[CTRL_LSB +: CTRL_W];
    assign f_mode  = mode_e'(uword[MODE_LSB +: MODE_W]);
    assign f_cinv  = uword[CINV_LSB];
    assign f_csel  = uword[CSEL_LSB +: CSEL_W];
    assign f_naddr = uword[ADDR_W-1:0];

    // Wraps naturally at the top of the control store.
    assign upc_inc = upc_q + ADDR_W'(1);

    assign uaddr          = upc_q;
    assign bus_controller = reset ? '0 : f_ctrl;
    assign halted         = (f_mode == M_HALT) && !reset;
    assign stack_err      = stack_err_q;

    // Selected condition; a csel beyond the populated inputs reads as 0.
    always_comb begin
        cond_bit = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            if (f_csel == CSEL_W'(i)) cond_bit = cond[i];
        end
    end

    always_comb begin
        upc_d       = upc_q;
        stack_err_d = stack_err_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        case (f_mode)
            M_NEXT:  upc_d = upc_inc;
            M_JUMP:  upc_d = f_naddr;
            M_CJUMP: upc_d = (cond_bit ^ f_cinv) ? f_naddr : upc_inc;
            M_MAP:   upc_d = map_addr;
            M_CALL: begin
                // Overflow drops the return address but still enters the routine.
                stk_push = !stk_full;
                if (stk_full) stack_err_d = 1'b1;
                upc_d = f_naddr;
            end
            M_RET: begin
                if (stk_empty) begin
                    stack_err_d = 1'b1;
                    upc_d       = RESET_UADDR;
                end else begin
                    stk_pop = 1'b1;
                    upc_d   = stk_dout;
                end
            end
            M_WAIT:  upc_d = wait_ ? upc_inc : upc_q;
            M_HALT:  upc_d = upc_q;
            default: upc_d = upc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q       <= RESET_UADDR;
            stack_err_q <= 1'b0;
        end else begin
            upc_q       <= upc_d;
            stack_err_q <= stack_err_d;
        end
    end

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: tb/tb_microseq.sv
// Bench for microseq with ADDR_W=4, CTRL_W=22, NCOND=4, STACK_DEPTH=2.
// The control store is an array in the bench read combinationally by uaddr.
module tb_microseq;

    localparam int DEPTH  = 2;
    localparam int NWORDS = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  uaddr;
    logic [31:0] uword;
    logic [3:0]  cond = 4'd0;
    logic [3:0]  map_addr = 4'd0;
    logic        wait_ = 1'b1;
    logic [21:0] bus_controller;
    logic        halted;
    logic        stack_err;

    logic [31:0] rom [NWORDS];

    always #5 clk = ~clk;

    assign uword = rom[uaddr];

    microseq #(
        .ADDR_W      (4),
        .CTRL_W      (22),
        .NCOND       (4),
        .CSEL_W      (2),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .uaddr          (uaddr),
        .uword          (uword),
        .cond           (cond),
        .map_addr       (map_addr),
        .wait_          (wait_),
        .bus_controller (bus_controller),
        .halted         (halted),
        .stack_err      (stack_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Microword builder: ctrl[31:10] mode[9:7] cinv[6] csel[5:4] naddr[3:0].
    function automatic logic [31:0] mk(input int ctrl, input int mode, input int cinv,
                                       input int csel, input int naddr);
        logic [31:0] w;
        w = (32'(ctrl) << 10) | (32'(mode) << 7) | (32'(cinv) << 6)
          | (32'(csel) << 4) | 32'(naddr);
        return w;
    endfunction

    // ---------------- behavioural model ----------------
    int         m_upc = 0;
    int         m_stk [$];
    bit         m_err = 1'b0;
    bit         m_valid = 1'b0;
    logic [3:0] exp_q [$];

    always @(posedge clk) begin : model
        logic [31:0] w;
        int mode, cinv, csel, naddr;
        if (reset) begin
            m_upc = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else begin
            w     = rom[m_upc];
            mode  = int'(w[9:7]);
            cinv  = int'(w[6]);
            csel  = int'(w[5:4]);
            naddr = int'(w[3:0]);
            case (mode)
                0: m_upc = (m_upc + 1) % NWORDS;
                1: m_upc = naddr;
                2: m_upc = ((int'(cond[csel]) ^ cinv) != 0) ? naddr : (m_upc + 1) % NWORDS;
                3: m_upc = int'(map_addr);
                4: begin
                    if (m_stk.size() == DEPTH) m_err = 1'b1;
                    else m_stk.push_back((m_upc + 1) % NWORDS);
                    m_upc = naddr;
                end
                5: begin
                    if (m_stk.size() > 0) m_upc = m_stk.pop_back();
                    else begin
                        m_err = 1'b1;
                        m_upc = 0;
                    end
                end
                6: if (wait_) m_upc = (m_upc + 1) % NWORDS;
                default: ;
            endcase
        end
        m_valid = 1'b1;
        exp_q.push_back(4'(m_upc));
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        logic [3:0]  exp_a;
        logic [31:0] w;
        if (m_valid && exp_q.size() > 0) begin
            exp_a = exp_q.pop_front();
            w     = rom[m_upc];
            chk("sb_uaddr", int'(uaddr), int'(exp_a));
            chk("sb_bus", int'(bus_controller), reset ? 0 : int'(w[31:10]));
            chk("sb_halted", int'(halted), int'(!reset && (w[9:7] == 3'd7)));
            chk("sb_stack_err", int'(stack_err), int'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Restart through reset and a JUMP at word 0 so the next word is `a`.
    task automatic go_to(input int a);
        reset  = 1'b1;
        rom[0] = mk(0, 1, 0, 0, a);
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    function automatic logic [31:0] rnd_word();
        int mode;
        mode = $urandom_range(0, 7);
        if (mode == 7 && $urandom_range(0, 3) != 0) mode = 0;
        return mk($urandom_range(0, 22'h3fffff), mode, $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 15));
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        for (int i = 0; i < NWORDS; i++) rom[i] = mk(0, 7, 0, 0, 0);

        // Reset and sequential flow.
        rom[0] = mk(1, 0, 0, 0, 0);
        rom[1] = mk(2, 0, 0, 0, 0);
        rom[2] = mk(3, 0, 0, 0, 0);
        rom[3] = mk(16'h33, 2, 0, 1, 9);
        rom[9] = mk(16'h99, 7, 0, 0, 0);
        reset = 1'b1;
        cyc();
        chk("rst_uaddr0", int'(uaddr), 0);
        chk("rst_bus0", int'(bus_controller), 0);
        cyc();
        chk("rst_uaddr1", int'(uaddr), 0);
        chk("rst_bus1", int'(bus_controller), 0);
        reset = 1'b0;
        #1;
        chk("seq_bus_a0", int'(bus_controller), 1);
        cyc();
        chk("seq_uaddr1", int'(uaddr), 1);
        chk("seq_bus_a1", int'(bus_controller), 2);
        cyc();
        chk("seq_uaddr2", int'(uaddr), 2);
        chk("seq_bus_a2", int'(bus_controller), 3);

        // Conditional branch.
        cond = 4'b0010;
        cyc();
        chk("cj_at3", int'(uaddr), 3);
        cyc();
        chk("cj_taken", int'(uaddr), 9);
        go_to(3);
        cond = 4'b0000;
        cyc();
        chk("cj_not_taken", int'(uaddr), 4);
        rom[3] = mk(16'h33, 2, 1, 1, 9);
        go_to(3);
        cyc();
        chk("cj_inverted", int'(uaddr), 9);

        // Wait stall.
        rom[5] = mk(16'h155, 6, 0, 0, 0);
        rom[6] = mk(16'h66, 7, 0, 0, 0);
        go_to(5);
        wait_ = 1'b0;
        chk("wait_uaddr_0", int'(uaddr), 5);
        chk("wait_bus_0", int'(bus_controller), 16'h155);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk($sformatf("wait_uaddr_%0d", i), int'(uaddr), 5);
            chk($sformatf("wait_bus_%0d", i), int'(bus_controller), 16'h155);
        end
        wait_ = 1'b1;
        cyc();
        chk("wait_release", int'(uaddr), 6);

        // Map and wrap.
        rom[10] = mk(16'hA, 3, 0, 0, 0);
        go_to(10);
        map_addr = 4'd12;
        cyc();
        chk("map_dispatch", int'(uaddr), 12);
        rom[15] = mk(16'hF, 0, 0, 0, 0);
        go_to(15);
        cyc();
        chk("next_wrap", int'(uaddr), 0);

        // Call / return nesting.
        rom[1]  = mk(16'h11, 4, 0, 0, 8);
        rom[8]  = mk(16'h88, 4, 0, 0, 12);
        rom[12] = mk(16'hCC, 5, 0, 0, 0);
        rom[9]  = mk(16'h99, 5, 0, 0, 0);
        rom[2]  = mk(16'h22, 7, 0, 0, 0);
        go_to(1);
        cyc();
        chk("call_to8", int'(uaddr), 8);
        cyc();
        chk("call_to12", int'(uaddr), 12);
        cyc();
        chk("ret_to9", int'(uaddr), 9);
        cyc();
        chk("ret_to2", int'(uaddr), 2);
        chk("nest_no_err", int'(stack_err), 0);

        // Halt.
        rom[7] = mk(16'h77, 7, 0, 0, 0);
        go_to(7);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("halt_uaddr_%0d", i), int'(uaddr), 7);
            chk($sformatf("halt_flag_%0d", i), int'(halted), 1);
        end

        // Overflow on a third nested call, then reset mid-chain.
        rom[12] = mk(16'hCC, 4, 0, 0, 14);
        rom[14] = mk(16'hEE, 4, 0, 0, 1);
        go_to(1);
        cyc();
        cyc();
        cyc();
        chk("ovf_jump", int'(uaddr), 14);
        chk("ovf_err", int'(stack_err), 1);
        rom[0] = mk(16'h5A, 7, 0, 0, 0);
        reset  = 1'b1;
        cyc();
        chk("midrst_uaddr", int'(uaddr), 0);
        chk("midrst_err", int'(stack_err), 0);
        chk("midrst_halted", int'(halted), 0);
        chk("midrst_bus", int'(bus_controller), 0);
        // A RET right after reset must underflow, proving the stack emptied.
        rom[0] = mk(16'h5B, 5, 0, 0, 3);
        reset  = 1'b0;
        cyc();
        chk("udf_uaddr", int'(uaddr), 0);
        chk("udf_err", int'(stack_err), 1);

        // Randomized program and inputs.
        for (int i = 0; i < NWORDS; i++) rom[i] = rnd_word();
        for (int n = 0; n < 3000; n++) begin
            cond     = 4'($urandom_range(0, 15));
            map_addr = 4'($urandom_range(0, 15));
            wait_    = ($urandom_range(0, 2) != 0);
            reset    = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 7) == 0) rom[$urandom_range(0, NWORDS - 1)] = rnd_word();
            cyc();
        end
        reset = 1'b0;
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
